mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, range 1..255: max cycles an access waits for mem_valid before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  fetch-stage read request, held until if_ready.
REQ-005 SHALL have port if_addr  input  32  fetch address, stable while if_req high.
REQ-006 SHALL have ports if_ready (output, 1) and if_rdata (output, 32): fetch completion strobe and read data.
REQ-007 SHALL have port dm_req  input  1  memory-stage request, held until dm_ready.
REQ-008 SHALL have ports dm_we (input, 1), dm_addr (input, 32), dm_wdata (input, 32): write enable, address, store data; stable while dm_req high.
REQ-009 SHALL have ports dm_ready (output, 1) and dm_rdata (output, 32): data-port completion strobe and load data.
REQ-010 SHALL have ports mem_en, mem_we (output, 1), mem_addr, mem_wdata (output, 32): shared single-port memory request.
REQ-011 SHALL have ports mem_rdata (input, 32) and mem_valid (input, 1): memory read data and one-cycle completion.
REQ-012 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, IF_BUSY, DM_BUSY.
REQ-014 In IDLE: dm_req -> DM_BUSY; else if_req -> IF_BUSY; else stay. Data port has priority on simultaneous requests.
REQ-015 On grant edge SHALL register mem_addr, mem_we, mem_wdata from the granted port; IF grant sets mem_we=0, mem_wdata=0.
REQ-016 mem_en SHALL be 1 exactly while state is IF_BUSY or DM_BUSY; mem_addr/mem_we/mem_wdata stable throughout.
REQ-017 Grant latency: request sampled in IDLE at cycle N -> mem_en=1 from cycle N+1.
REQ-018 Completion: mem_valid=1 in a BUSY state -> granted port's ready=1 combinationally that same cycle; rdata = mem_rdata. Writes also complete on mem_valid.
REQ-019 Ready SHALL be 1 for exactly one cycle per access; the non-granted port's ready SHALL be 0.
REQ-020 if_rdata/dm_rdata SHALL be 0 whenever the respective ready is 0.
REQ-021 On completion edge, if the other port's req is high, SHALL go directly to that port's BUSY state (no IDLE cycle); else IDLE. The completing port is never regranted on its own completion edge.
REQ-022 With both reqs continuously high, grants SHALL strictly alternate DM, IF, DM, IF ...
REQ-023 mem_valid in IDLE SHALL be ignored (no ready, no state change).
REQ-024 SHALL keep 8-bit wait counter: cleared on every grant; increments each BUSY cycle without mem_valid.
REQ-025 When counter reaches TIMEOUT with mem_valid=0 SHALL abort: granted port ready=1 for one cycle with rdata=0, err set, transition per REQ-021.
REQ-026 mem_valid in the abort cycle SHALL take precedence (normal completion, err unchanged).
REQ-027 err once set SHALL stay 1 until reset.
REQ-028 Request changes while a port waits SHALL be a protocol violation; block needs no behaviour for them.

Reset
REQ-029 reset=1 at clock edge SHALL force: state IDLE, counter 0, err 0, mem_en/mem_we 0, mem_addr/mem_wdata 0.
REQ-030 While in reset and first cycle after, if_ready, dm_ready, rdata outputs SHALL be 0.
REQ-031 Reset mid-access SHALL abandon the access; a late mem_valid afterward SHALL be ignored per REQ-023.

Verification
REQ-032 Reset: reset=1 two cycles, random inputs -> mem_en=0, if_ready=0, dm_ready=0, err=0.
REQ-033 Lone fetch: if_req=1, if_addr=0x00000004 at cycle 0; mem_valid=1, mem_rdata=0x00500113 at cycle 3 -> mem_en=1 cycles 1-3, mem_addr=0x4, mem_we=0; if_ready=1, if_rdata=0x00500113 cycle 3 only.
REQ-034 Simultaneous: if_req and dm_req (dm_we=1, addr=100, wdata=25) at cycle 0; mem_valid cycle 2 -> cycles 1-2 mem_we=1, mem_addr=100, mem_wdata=25, dm_ready cycle 2; IF granted cycle 3 with no IDLE gap.
REQ-035 Alternation: both reqs held, mem_valid every 2nd BUSY cycle -> grant order DM, IF, DM, IF; each ready pulses once per access.
REQ-036 Timeout: TIMEOUT=4, dm_req=1, mem_valid never -> dm_ready=1, dm_rdata=0 on 4th BUSY cycle; err=1 thereafter until reset.
REQ-037 Reset mid-access: reset during DM_BUSY, mem_valid=1 cycle after reset -> dm_ready=0, mem_en=0, state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between a fetch port and a data port.
// The data port wins a simultaneous request; continuous contention alternates grants; stalled accesses abort after TIMEOUT cycles.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    // The abort fires on the TIMEOUT-th busy cycle, when TIMEOUT-1 empty cycles have already been counted.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       busy;
    logic       timed_out;
    logic       done;
    logic       grant_if;
    logic       grant_dm;

    assign busy      = (state != IDLE);
    assign timed_out = busy && !mem_valid && (wait_cnt >= LAST_WAIT);
    assign done      = busy && !reset && (mem_valid || timed_out);
    assign mem_en    = busy;

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        unique case (state)
            IDLE: begin
                if (dm_req) begin
                    grant_dm = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end
            end
            IF_BUSY: begin
                if (done) begin
                    if (dm_req) grant_dm   = 1'b1;
                    else        state_next = IDLE;
                end
            end
            DM_BUSY: begin
                if (done) begin
                    if (if_req) grant_if   = 1'b1;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (grant_dm) state_next = DM_BUSY;
        if (grant_if) state_next = IF_BUSY;
    end

    always_comb begin
        if_ready = done && (state == IF_BUSY);
        dm_ready = done && (state == DM_BUSY);
        if_rdata = (if_ready && mem_valid) ? mem_rdata : 32'd0;
        dm_rdata = (dm_ready && mem_valid) ? mem_rdata : 32'd0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            state <= state_next;
            if (grant_dm) begin
                mem_addr  <= dm_addr;
                mem_we    <= dm_we;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_addr  <= if_addr;
                mem_we    <= 1'b0;
                mem_wdata <= 32'd0;
            end
            if (grant_dm || grant_if || done) begin
                wait_cnt <= 8'd0;
            end else if (busy) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (done && !mem_valid) begin
                err <= 1'b1;
            end
        end
    end

endmodule
